// File: rtl/sample_capture_pkg.sv
// Shared types and helpers for the logic-analyzer sample capture buffer.
package sample_capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        READ  = 3'd4
    } cap_state_t;

    // Saturate a requested sample count at the space that is actually available.
    function automatic int unsigned clamp_cnt(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/sample_bram_bank.sv
// Single-port sample RAM bank with write enable and a 1-cycle registered read.
module sample_bram_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WORDS  = 8192
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: neither the array nor the read register is reset, so the bank maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sample_capture_buffer.sv
// Banked capture buffer: rolling pre-trigger window, post-trigger fill,
// then oldest-first readout through a 2-entry output skid buffer.
module sample_capture_buffer
    import sample_capture_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 32768,
    parameter  int unsigned BANKS  = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [CNT_W-1:0]  pre_count,
    input  logic [CNT_W-1:0]  post_count,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              trigger,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_count,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned BANK_W = $clog2(BANKS);
    localparam int unsigned WORDS  = DEPTH / BANKS;
    localparam int unsigned BA_W   = ADDR_W - BANK_W;

    cap_state_t        state_q, state_d;
    logic [CNT_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  post_q, post_d;
    logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BANK_W-1:0] bank_sel_q, bank_sel_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    logic [CNT_W-1:0]  pre_lim;
    logic [CNT_W-1:0]  post_lim;
    logic              wr_en;
    logic              rd_en;
    logic              pop;
    logic [2:0]        occupancy;
    logic [BANK_W-1:0] wr_bank;
    logic [BANK_W-1:0] rd_bank;
    logic [BA_W-1:0]   ram_addr;
    logic [BANKS-1:0]  bank_en;
    logic [DATA_W-1:0] bank_rdata [BANKS];
    logic [DATA_W-1:0] ram_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            post_q     <= '0;
            post_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            bank_sel_q <= '0;
            inflight_q <= 1'b0;
            skid_cnt_q <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            post_cnt_q <= post_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            bank_sel_q <= bank_sel_d;
            inflight_q <= inflight_d;
            skid_cnt_q <= skid_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign pop = out_valid && out_ready;

    // Entries already held plus the one arriving from RAM, net of this cycle's pop.
    assign occupancy = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        post_d     = post_q;
        post_cnt_d = post_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;

        pre_lim  = CNT_W'(clamp_cnt(32'(pre_count), DEPTH));
        post_lim = CNT_W'(clamp_cnt(32'(post_count), DEPTH - 32'(pre_lim)));

        case (state_q)
            IDLE: begin
                if (arm) begin
                    pre_d      = pre_lim;
                    post_d     = post_lim;
                    post_cnt_d = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    state_d    = (pre_lim == '0) ? ARMED : PRE;
                end
            end
            PRE: begin
                if (sample_en) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + CNT_W'(1);
                    count_d  = count_q + CNT_W'(1);
                    if (count_q + CNT_W'(1) == pre_q) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (sample_en && trigger) begin
                    if (post_q == '0) begin
                        state_d = READ;
                    end else begin
                        wr_en      = 1'b1;
                        wr_ptr_d   = wr_ptr_q + CNT_W'(1);
                        count_d    = count_q + CNT_W'(1);
                        post_cnt_d = CNT_W'(1);
                        state_d    = (post_q == CNT_W'(1)) ? READ : POST;
                    end
                end else if (sample_en) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + CNT_W'(1);
                    // Window full: the oldest sample slides out as the new one lands.
                    if (count_q == pre_q) begin
                        rd_ptr_d = rd_ptr_q + CNT_W'(1);
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            POST: begin
                if (sample_en) begin
                    wr_en      = 1'b1;
                    wr_ptr_d   = wr_ptr_q + CNT_W'(1);
                    count_d    = count_q + CNT_W'(1);
                    post_cnt_d = post_cnt_q + CNT_W'(1);
                    if (post_cnt_q + CNT_W'(1) == post_q) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                rd_en   = (rd_ptr_q != wr_ptr_q) && (occupancy <= 3'd1);
                count_d = count_q - CNT_W'(pop);
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + CNT_W'(1);
                end
                if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            wr_en    = 1'b0;
            rd_en    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output skid buffer: head_q is the presented beat, tail_q the spare slot
    // ------------------------------------------------------------------
    always_comb begin
        skid_cnt_d = skid_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        bank_sel_d = rd_en ? rd_bank : bank_sel_q;
        inflight_d = rd_en;

        case (skid_cnt_q)
            2'd0: begin
                if (inflight_q) begin
                    head_d     = ram_rdata;
                    skid_cnt_d = 2'd1;
                end
            end
            2'd1: begin
                case ({inflight_q, pop})
                    2'b11:   head_d = ram_rdata;
                    2'b10:   begin
                        tail_d     = ram_rdata;
                        skid_cnt_d = 2'd2;
                    end
                    2'b01:   skid_cnt_d = 2'd0;
                    default: skid_cnt_d = 2'd1;
                endcase
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (inflight_q) begin
                        tail_d = ram_rdata;
                    end else begin
                        skid_cnt_d = 2'd1;
                    end
                end
            end
            default: begin
                skid_cnt_d = 2'd0;
            end
        endcase

        if (abort) begin
            skid_cnt_d = 2'd0;
            inflight_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM-derived outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy         = state_q inside {PRE, ARMED, POST};
        done         = (state_q == READ);
        out_valid    = (skid_cnt_q != 2'd0);
        out_data     = head_q;
        sample_count = count_q;
    end

    // ------------------------------------------------------------------
    // Bank decode and RAM banks
    // ------------------------------------------------------------------
    always_comb begin
        wr_bank   = wr_ptr_q[ADDR_W-1 -: BANK_W];
        rd_bank   = rd_ptr_q[ADDR_W-1 -: BANK_W];
        ram_addr  = wr_en ? wr_ptr_q[BA_W-1:0] : rd_ptr_q[BA_W-1:0];
        ram_rdata = bank_rdata[bank_sel_q];
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        assign bank_en[g] = (wr_en && (wr_bank == BANK_W'(g))) ||
                            (rd_en && (rd_bank == BANK_W'(g)));

        sample_bram_bank #(
            .DATA_W (DATA_W),
            .WORDS  (WORDS)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (wr_en),
            .addr  (ram_addr),
            .wdata (data_in),
            .rdata (bank_rdata[g])
        );
    end

endmodule
